// File: rtl/rz_sel_arb_if.sv
// -----------------------------------------------------------------------------
// rz_sel_arb_if
// Purpose : bundles the N-channel request side and the single registered
//           output side of the rz_sel_arb selector/arbiter.
// Parameters:
//   W  - width of each channel's data field
//   N  - number of input channels
//   SW - derived width of the source index, max(1, ceil(log2(N)))
// Signals:
//   in_valid  [N]   per-channel request
//   in_data   [N*W] channel i field in bits [i*W +: W]
//   in_ready  [N]   one-hot or zero acceptance strobe
//   out_valid       output register holds an entry
//   out_data  [W]   selected field
//   out_src   [SW]  index of the channel that supplied out_data
//   out_ready       downstream consumes the entry
// Modports:
//   master - the environment (drives requests, consumes output)
//   slave  - the arbiter
// -----------------------------------------------------------------------------
interface rz_sel_arb_if #(
    parameter int W = 3,
    parameter int N = 4
);
    localparam int SW = ($clog2(N) < 1) ? 1 : $clog2(N);

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rz_sel_arb.sv
// -----------------------------------------------------------------------------
// rz_sel_arb
// Purpose : N-input selector feeding a single-entry registered output stage.
//           Each cycle one valid channel is granted and its field is captured
//           into the output register whenever that register can be loaded
//           (empty, or being consumed in the same cycle).
// Configuration:
//   RZ_SEL_ARB_RR_EN defined   -> round-robin arbitration from a priority
//                                 pointer that advances past each winner.
//   RZ_SEL_ARB_RR_EN undefined -> fixed priority, lowest index wins; no
//                                 pointer is built.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - rz_sel_arb_if.slave (requests in, registered entry out)
// -----------------------------------------------------------------------------
module rz_sel_arb #(
    parameter int W = 3,
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rz_sel_arb_if.slave   bus
);
    localparam int SW = ($clog2(N) < 1) ? 1 : $clog2(N);

    logic [N-1:0]  w_grant;
    logic [SW-1:0] w_gidx;
    logic [W-1:0]  w_gdata;
    logic          w_found;
    logic          w_load;

    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_src;

`ifdef RZ_SEL_ARB_RR_EN
    logic [SW-1:0] r_ptr;
`endif

    // The output register can take a new entry when empty or being drained.
    assign w_load = ~r_out_valid | bus.out_ready;

    // Grant search: first valid channel starting at the priority origin.
    always_comb begin
        w_grant = {N{1'b0}};
        w_gidx  = {SW{1'b0}};
        w_gdata = {W{1'b0}};
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
`ifdef RZ_SEL_ARB_RR_EN
            // Scan ptr, ptr+1, ... wrapping modulo N; ptr is always < N.
            idx = int'(r_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
`else
            idx = k;
`endif
            if (!w_found && bus.in_valid[idx]) begin
                w_found      = 1'b1;
                w_grant[idx] = 1'b1;
                w_gidx       = SW'(idx);
                w_gdata      = bus.in_data[idx*W +: W];
            end else begin
                w_found = w_found;
            end
        end
    end

    // Acknowledge only when the entry is really captured; nothing during reset.
    assign bus.in_ready = w_grant & {N{w_load & rst_n}};

    // Output entry register: load, drain-to-empty, or hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {W{1'b0}};
            r_out_src   <= {SW{1'b0}};
        end else if (w_load) begin
            if (w_found) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gdata;
                r_out_src   <= w_gidx;
            end else begin
                // Nothing to capture: mark empty but keep the stale payload.
                r_out_valid <= 1'b0;
            end
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

`ifdef RZ_SEL_ARB_RR_EN
    // Priority pointer moves just past the winner of an accepted transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= {SW{1'b0}};
        end else if (w_load && w_found) begin
            if (w_gidx == SW'(N - 1)) begin
                r_ptr <= {SW{1'b0}};
            end else begin
                r_ptr <= w_gidx + {{(SW-1){1'b0}}, 1'b1};
            end
        end else begin
            r_ptr <= r_ptr;
        end
    end
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;

endmodule

// File: tb/tb_rz_sel_arb.sv
// -----------------------------------------------------------------------------
// tb_rz_sel_arb
// Directed vectors for rz_sel_arb (W=3, N=4). Each vector states the inputs
// for one cycle plus the hand-computed in_ready and out_valid. An accepted
// transfer pushes its {src,data} into a scoreboard queue; a separate monitor
// compares the queue head with the output register whenever out_valid is set
// and pops it when the entry is consumed.
// -----------------------------------------------------------------------------
module tb_rz_sel_arb;
    localparam int W = 3;
    localparam int N = 4;

    typedef struct packed {
        logic        rst;
        logic [3:0]  v;
        logic [11:0] d;
        logic        ord;
        logic [3:0]  rdy;
        logic        chk_ov;
        logic        ov;
        logic        chk_z;
    } vec_t;

    logic clk;
    logic rst_n;
    rz_sel_arb_if #(.W(W), .N(N)) bus ();

    rz_sel_arb #(.W(W), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   compared;
    int   mismatched;
    logic mon_en;
    logic [4:0] sb [$];
    vec_t vq [$];

    // Channel i carries i+1; variants used for the stall test.
    localparam logic [11:0] D_BASE = 12'h8D1;
    localparam logic [11:0] D_CH1_5 = 12'h8E9;
    localparam logic [11:0] D_CH0_5 = 12'h8D5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] v, input logic [11:0] d,
                       input logic ord, input logic [3:0] rdy,
                       input logic chk_ov, input logic ov, input logic chk_z);
        vec_t t;
        t.rst = r; t.v = v; t.d = d; t.ord = ord; t.rdy = rdy;
        t.chk_ov = chk_ov; t.ov = ov; t.chk_z = chk_z;
        vq.push_back(t);
    endtask

    // Monitor: output register must always match the oldest accepted entry.
    always @(negedge clk) begin
        if (mon_en && bus.out_valid) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_output: got src=%0d data=%0d, required no valid entry",
                         bus.out_src, bus.out_data);
            end else begin
                if ({bus.out_src, bus.out_data} !== sb[0]) begin
                    mismatched++;
                    $display("FAIL out_entry: got src=%0d data=%0d, required src=%0d data=%0d",
                             bus.out_src, bus.out_data, sb[0][4:3], sb[0][2:0]);
                end
                if (bus.out_ready) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic prev_rst;
        compared   = 0;
        mismatched = 0;
        mon_en     = 1'b0;
        rst_n      = 1'b0;
        bus.in_valid  = 4'b0000;
        bus.in_data   = D_BASE;
        bus.out_ready = 1'b0;

`ifdef RZ_SEL_ARB_RR_EN
        add(1'b0, 4'hF, D_BASE,  1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'hF, D_BASE,  1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
        add(1'b1, 4'hF, D_BASE,  1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, D_BASE,  1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hF, D_BASE,  1'b1, 4'b0100, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hF, D_BASE,  1'b1, 4'b1000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hF, D_CH0_5, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hF, D_BASE,  1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hF, D_BASE,  1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hF, D_BASE,  1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hF, D_BASE,  1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'h4, D_BASE,  1'b1, 4'b0100, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'h2, D_BASE,  1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hA, D_BASE,  1'b1, 4'b1000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hA, D_BASE,  1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'h0, D_BASE,  1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'h0, D_BASE,  1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'h4, D_BASE,  1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'h4, D_BASE,  1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'h4, D_BASE,  1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hF, D_BASE,  1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'h0, D_BASE,  1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'h0, D_BASE,  1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
`else
        add(1'b0, 4'hF, D_BASE,  1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'hF, D_BASE,  1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
        add(1'b1, 4'hF, D_BASE,  1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, D_BASE,  1'b1, 4'b0001, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hA, D_BASE,  1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hA, D_BASE,  1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hA, D_BASE,  1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hA, D_CH1_5, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hF, D_BASE,  1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hF, D_BASE,  1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hF, D_BASE,  1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hF, D_BASE,  1'b1, 4'b0001, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'h0, D_BASE,  1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'h0, D_BASE,  1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'h4, D_BASE,  1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'h4, D_BASE,  1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'h4, D_BASE,  1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'h4, D_BASE,  1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'h8, D_BASE,  1'b1, 4'b1000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'h0, D_BASE,  1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'h0, D_BASE,  1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
`endif

        prev_rst = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            vec_t t;
            t = vq[i];
            @(posedge clk);
            #1;
            // A reset edge has just discarded whatever the output register held.
            if (!prev_rst) begin
                sb.delete();
            end
            if (i >= 1) begin
                mon_en = 1'b1;
            end
            rst_n         = t.rst;
            bus.in_valid  = t.v;
            bus.in_data   = t.d;
            bus.out_ready = t.ord;
            prev_rst      = t.rst;

            @(negedge clk);
            compared++;
            if (bus.in_ready !== t.rdy) begin
                mismatched++;
                $display("FAIL in_ready[v%0d]: got %b, required %b", i, bus.in_ready, t.rdy);
            end
            if (t.chk_ov) begin
                compared++;
                if (bus.out_valid !== t.ov) begin
                    mismatched++;
                    $display("FAIL out_valid[v%0d]: got %b, required %b", i, bus.out_valid, t.ov);
                end
            end
            if (t.chk_z) begin
                compared++;
                if (bus.out_data !== 3'd0 || bus.out_src !== 2'd0) begin
                    mismatched++;
                    $display("FAIL reset_payload[v%0d]: got src=%0d data=%0d, required src=0 data=0",
                             i, bus.out_src, bus.out_data);
                end
            end
            // Record the accepted transfer implied by the hand-computed in_ready.
            for (int c = 0; c < N; c++) begin
                if (t.rdy[c]) begin
                    logic [1:0]  s;
                    logic [11:0] dv;
                    s  = 2'(c);
                    dv = t.d;
                    sb.push_back({s, dv[c*W +: W]});
                end
            end
        end

        @(posedge clk);
        #1;
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d entries outstanding, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rz_sel_arb.md
RZ_SEL_ARB -- requirements
Module: rz_sel_arb

Interface
REQ-001 Parameter W, default 3: width of each channel's register-address/data field.
REQ-002 Parameter N, default 4: number of input channels (2..16).
REQ-003 Parameter SW is derived as max(1, ceil(log2(N))): width of the source-index output.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1: reset, synchronous and active-low.
REQ-006 in_valid  in  N: per-channel request; bit i qualifies channel i.
REQ-007 in_data  in  N*W: channel i field in bits [i*W +: W].
REQ-008 in_ready  out  N: one-hot or zero; bit i is high when channel i's transfer is accepted this cycle.
REQ-009 out_valid  out  1: output register holds a valid entry.
REQ-010 out_data  out  W: selected field (RZ).
REQ-011 out_src  out  SW: index of the channel that supplied out_data.
REQ-012 out_ready  in  1: downstream consumes the entry when out_valid and out_ready are both high.

Function
REQ-013 The block is a single-entry registered output stage; load = !out_valid | out_ready.
REQ-014 grant is computed combinationally each cycle from in_valid and the priority pointer ptr (SW bits); at most one bit is set.
REQ-015 Round-robin: the granted channel is the first valid channel found scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
REQ-016 in_ready = grant & {N{load}}; no in_ready bit is high when in_valid is all zero.
REQ-017 On a cycle with load high and a grant on channel g: out_data <= in_data[g], out_src <= g, out_valid <= 1, with latency 1 cycle from acceptance to out_valid.
REQ-018 On a cycle with load high and no valid input: out_valid <= 0 and out_data/out_src hold their previous values.
REQ-019 Output held, no load: out_valid=1 and out_ready=0 keeps out_data, out_src, and out_valid stable, and all in_ready bits are 0.
REQ-020 Simultaneous consume and load: the new entry replaces the consumed one in the same edge, giving sustained throughput of 1 transfer per cycle.
REQ-021 ptr updates only on an accepted transfer, to g+1, wrapping from N-1 to 0; otherwise ptr holds its value.
REQ-022 Sources hold in_data stable while in_valid is high and in_ready is low; the grant may move to a different channel while the output is stalled.
REQ-023 With N not a power of two, ptr values >= N never occur.

Reset
REQ-024 When rst_n=0 at a clock edge: out_valid=0, out_data=0, out_src=0, ptr=0.
REQ-025 in_ready is forced to 0 while rst_n=0.
REQ-026 Reset during a stalled or in-flight transfer discards the held entry, and no channel is acknowledged.

Configuration
REQ-027 Macro RZ_SEL_ARB_RR_EN defined: round-robin arbitration per REQ-015 and REQ-021.
REQ-028 Macro RZ_SEL_ARB_RR_EN undefined: fixed priority applies, with the lowest-indexed valid channel winning; ptr is not implemented, and all other behaviour is unchanged.

Verification
REQ-029 Reset with in_valid=4'b1111 held -> out_valid=0, out_data=0, out_src=0, in_ready=0 during reset; after release, the first grant goes to channel 0.
REQ-030 With RR enabled, in_valid=4'b1111, out_ready=1 constant, data ch i = i+1 -> out_src sequence is 0,1,2,3,0,... on consecutive cycles, and out_data follows 1,2,3,4,1.
REQ-031 Stall test: out_valid=1 with out_data=3'd5, out_ready=0 for 3 cycles, other channels valid -> out_data stays 5, in_ready=0 throughout; on out_ready=1 the next entry loads on the same edge.
REQ-032 Wrap test: ptr=3 with only ch1 valid -> ch1 is granted, after which ptr=2; a subsequent grant of ch3 makes ptr wrap to 0.
REQ-033 With RR disabled, in_valid=4'b1010 held and out_ready=1 -> out_src is always 1, and channel 3 is never granted.
REQ-034 Mid-operation reset: out_valid=1, out_ready=0, rst_n pulsed low for 1 cycle -> out_valid=0 on the next cycle, and no in_ready pulse is asserted during the reset cycle.
